// File: rtl/mem_capture_pkg.sv
// Shared types and field layout for the on-chip memory capture writer.
package mem_capture_pkg;
  typedef enum logic [2:0] {
    IDLE, RD_CMD, RD_WAIT, ACK, STAT_BUSY, CAPTURE, STAT_DONE
  } state_e;

  localparam int GO_BIT    = 31;
  localparam int DONE_BIT  = 31;
  localparam int BUSY_BIT  = 30;
  localparam int CLAMP_BIT = 29;
  localparam int CNT_W     = 16;

  function automatic logic [31:0] stat_word(input logic done, input logic bsy,
                                            input logic clamp, input logic [CNT_W-1:0] cnt);
    logic [31:0] w;
    w            = '0;
    w[DONE_BIT]  = done;
    w[BUSY_BIT]  = bsy;
    w[CLAMP_BIT] = clamp;
    w[CNT_W-1:0] = cnt;
    return w;
  endfunction
endpackage

// File: rtl/mem_capture_writer.sv
// Polls a mailbox word in on-chip memory, captures N stream words into a
// buffer region on command and posts busy/done status words.
module mem_capture_writer
  import mem_capture_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int BUF_BASE = 0,
  parameter int BUF_WORDS = 16384,
  parameter logic [ADDR_W-1:0] CMD_ADDR = 15'h7FFE,
  parameter logic [ADDR_W-1:0] STAT_ADDR = 15'h7FFF,
  parameter int POLL_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic [3:0]        mem_byteenable,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              busy,
  output logic              done_pulse
);
  localparam int PW = $clog2(POLL_CYCLES);

  state_e            state_q, state_d;
  logic [PW-1:0]     poll_q, poll_d;
  logic [DATA_W-1:0] cmd_q, cmd_d;
  logic [CNT_W-1:0]  neff_q, neff_d, idx_q, idx_d;
  logic              clamp_q, clamp_d;
  logic              en_q;
  logic [CNT_W-1:0]  n_req;
  logic              rdy;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      poll_q  <= '0;
      cmd_q   <= '0;
      neff_q  <= '0;
      idx_q   <= '0;
      clamp_q <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      poll_q  <= poll_d;
      cmd_q   <= cmd_d;
      neff_q  <= neff_d;
      idx_q   <= idx_d;
      clamp_q <= clamp_d;
      en_q    <= 1'b1;
    end
  end

  assign mem_clken      = en_q;
  assign mem_byteenable = 4'hF;
  assign n_req          = mem_readdata[CNT_W-1:0];

  always_comb begin
    state_d        = state_q;
    poll_d         = poll_q;
    cmd_d          = cmd_q;
    neff_d         = neff_q;
    idx_d          = idx_q;
    clamp_d        = clamp_q;
    rdy            = 1'b0;
    mem_address    = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;
    busy           = 1'b0;
    done_pulse     = 1'b0;
    case (state_q)
      IDLE: begin
        if (poll_q == PW'(POLL_CYCLES - 1)) begin
          poll_d  = '0;
          state_d = RD_CMD;
        end else begin
          poll_d = poll_q + 1'b1;
        end
      end
      RD_CMD: begin
        mem_chipselect = 1'b1;
        mem_address    = CMD_ADDR;
        state_d        = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_readdata[GO_BIT]) begin
          cmd_d   = mem_readdata;
          clamp_d = 32'(n_req) > BUF_WORDS;
          neff_d  = (32'(n_req) > BUF_WORDS) ? CNT_W'(BUF_WORDS) : n_req;
          idx_d   = '0;
          state_d = ACK;
        end else begin
          state_d = IDLE;
        end
      end
      ACK: begin
        busy           = 1'b1;
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_address    = CMD_ADDR;
        mem_writedata  = cmd_q & ~(DATA_W'(1) << GO_BIT);
        state_d        = STAT_BUSY;
      end
      STAT_BUSY: begin
        busy           = 1'b1;
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_address    = STAT_ADDR;
        mem_writedata  = DATA_W'(stat_word(1'b0, 1'b1, clamp_q, neff_q));
        state_d        = (neff_q == '0) ? STAT_DONE : CAPTURE;
      end
      CAPTURE: begin
        busy = 1'b1;
        rdy  = idx_q < neff_q;
        if (s_valid && rdy) begin
          mem_chipselect = 1'b1;
          mem_write      = 1'b1;
          mem_address    = ADDR_W'(BUF_BASE) + ADDR_W'(idx_q);
          mem_writedata  = s_data;
          idx_d          = idx_q + 1'b1;
          if (idx_d == neff_q) state_d = STAT_DONE;
        end
      end
      STAT_DONE: begin
        busy           = 1'b1;
        done_pulse     = 1'b1;
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_address    = STAT_ADDR;
        mem_writedata  = DATA_W'(stat_word(1'b1, 1'b0, clamp_q, neff_q));
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is a decode of registered state/index only; no path from s_valid.
  assign s_ready = rdy;
endmodule

// File: tb/tb_mem_capture_writer.sv
// Scoreboard bench: expected memory writes are queued by the stimulus and
// popped by a negedge monitor watching the s2 port.
module tb_mem_capture_writer;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;
  localparam int BUF_BASE = 32'h0100;
  localparam int BUF_WORDS = 8;
  localparam logic [14:0] CMD_ADDR = 15'h7FFE;
  localparam logic [14:0] STAT_ADDR = 15'h7FFF;
  localparam int POLL_CYCLES = 4;

  if (BUF_BASE + BUF_WORDS > int'(CMD_ADDR) || POLL_CYCLES < 2) begin : g_cfg_chk
    $error("buffer region overlaps mailbox or poll interval too short");
  end

  logic clk = 1'b0, reset_n = 1'b0, s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic s_ready, mem_chipselect, mem_clken, mem_write, busy, done_pulse;
  logic [14:0] mem_address;
  logic [31:0] mem_writedata, mem_readdata;
  logic [3:0] mem_byteenable;

  mem_capture_writer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUF_BASE(BUF_BASE), .BUF_WORDS(BUF_WORDS),
    .CMD_ADDR(CMD_ADDR), .STAT_ADDR(STAT_ADDR), .POLL_CYCLES(POLL_CYCLES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata), .busy(busy), .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:32767];
  logic [31:0] rdata_q = '0;
  assign mem_readdata = rdata_q;

  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) mem[mem_address] = mem_writedata;
      else rdata_q <= mem[mem_address];
    end
  end

  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, rd_cnt = 0, last_wr = 0, prev_wr = 0;
  bit ready_seen = 0, busy_seen = 0;
  logic [46:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [14:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  always @(negedge clk) begin
    logic [46:0] e;
    cyc++;
    if (done_pulse) done_cnt++;
    if (s_ready) ready_seen = 1;
    if (busy) busy_seen = 1;
    if (reset_n && mem_chipselect) begin
      checks++;
      if (mem_write) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr %h data %h, none expected", mem_address, mem_writedata);
        end else begin
          e = exp_q.pop_front();
          if ({mem_address, mem_writedata} !== e) begin
            errors++;
            $display("FAIL write: got addr %h data %h expected addr %h data %h",
                     mem_address, mem_writedata, e[46:32], e[31:0]);
          end
        end
        prev_wr = last_wr;
        last_wr = cyc;
      end else begin
        rd_cnt++;
        if (mem_address !== CMD_ADDR) begin
          errors++;
          $display("FAIL read_addr: got %h expected %h", mem_address, CMD_ADDR);
        end
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      errors++;
      $display("FAIL wait_ready: s_ready %b after %0d cycles, required 1", s_ready, t);
    end
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (done_cnt == d0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL wait_done: no done_pulse after %0d cycles", t);
    end
  endtask

  // Drives n words with a per-cycle valid pattern; also checks that chipselect
  // tracks the accept handshake in every capture cycle.
  task automatic stream(input int n, input logic [31:0] base, input logic [15:0] pat);
    int k = 0, c = 0;
    bit acc;
    while (k < n && c < 100) begin
      s_valid = pat[c % 16];
      s_data  = base + k;
      #1;
      chk("cs_vs_handshake", {31'b0, mem_chipselect}, {31'b0, s_valid && s_ready});
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
      c++;
    end
    s_valid = 1'b0;
    if (k < n) begin
      errors++;
      $display("FAIL stream: accepted %0d words, required %0d", k, n);
    end
  endtask

  initial begin
    int d0, r0;
    for (int i = 0; i < 32768; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_clken", {31'b0, mem_clken}, 32'd0);
    chk("rst_cs", {31'b0, mem_chipselect}, 32'd0);
    chk("rst_ready", {31'b0, s_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("clken_on", {31'b0, mem_clken}, 32'd1);
    chk("byteen", {28'b0, mem_byteenable}, 32'hF);

    // Basic 4-word capture, valid held high
    d0 = done_cnt;
    push(CMD_ADDR, 32'h0000_0004);
    push(STAT_ADDR, 32'h4000_0004);
    for (int i = 0; i < 4; i++) push(15'(BUF_BASE + i), 32'hA0 + i);
    push(STAT_ADDR, 32'h8000_0004);
    mem[CMD_ADDR] = 32'h8000_0004;
    wait_ready();
    stream(4, 32'hA0, 16'hFFFF);
    chk("ready_low_after_last", {31'b0, s_ready}, 32'd0);
    wait_done(d0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) chk("buffer", mem[BUF_BASE + i], 32'hA0 + i);
    chk("cmd_cleared", mem[CMD_ADDR], 32'h0000_0004);
    chk("status_done", mem[STAT_ADDR], 32'h8000_0004);
    chk("done_once", done_cnt - d0, 32'd1);
    chk("queue_empty_t1", exp_q.size(), 32'd0);

    // GO=0: polls only, no writes, never busy
    busy_seen = 0;
    r0 = rd_cnt;
    mem[CMD_ADDR] = 32'h0000_0010;
    repeat (60) @(negedge clk);
    chk("nogo_busy", {31'b0, busy_seen}, 32'd0);
    chk("nogo_polled", {31'b0, rd_cnt - r0 >= 3}, 32'd1);
    chk("nogo_cmd", mem[CMD_ADDR], 32'h0000_0010);

    // Gapped valid, 3 words
    d0 = done_cnt;
    push(CMD_ADDR, 32'h0000_0003);
    push(STAT_ADDR, 32'h4000_0003);
    for (int i = 0; i < 3; i++) push(15'(BUF_BASE + i), 32'hC0 + i);
    push(STAT_ADDR, 32'h8000_0003);
    mem[CMD_ADDR] = 32'h8000_0003;
    wait_ready();
    stream(3, 32'hC0, 16'b0000_0000_0010_1001);
    wait_done(d0);
    repeat (4) @(negedge clk);
    chk("gap_done_once", done_cnt - d0, 32'd1);
    chk("queue_empty_t3", exp_q.size(), 32'd0);

    // Zero-length command
    d0 = done_cnt;
    ready_seen = 0;
    push(CMD_ADDR, 32'h0000_0000);
    push(STAT_ADDR, 32'h4000_0000);
    push(STAT_ADDR, 32'h8000_0000);
    mem[CMD_ADDR] = 32'h8000_0000;
    wait_done(d0);
    repeat (4) @(negedge clk);
    chk("zero_back_to_back", last_wr - prev_wr, 32'd1);
    chk("zero_no_ready", {31'b0, ready_seen}, 32'd0);
    chk("zero_status", mem[STAT_ADDR], 32'h8000_0000);
    chk("queue_empty_t4", exp_q.size(), 32'd0);

    // Clamped request
    d0 = done_cnt;
    push(CMD_ADDR, 32'h0000_0020);
    push(STAT_ADDR, 32'h6000_0008);
    for (int i = 0; i < 8; i++) push(15'(BUF_BASE + i), 32'hD0 + i);
    push(STAT_ADDR, 32'hA000_0008);
    mem[CMD_ADDR] = 32'h8000_0020;
    wait_ready();
    stream(8, 32'hD0, 16'hFFFF);
    chk("clamp_ready_low", {31'b0, s_ready}, 32'd0);
    wait_done(d0);
    repeat (4) @(negedge clk);
    chk("clamp_status", mem[STAT_ADDR], 32'hA000_0008);
    chk("clamp_buf_last", mem[BUF_BASE + 7], 32'hD7);
    chk("queue_empty_t5", exp_q.size(), 32'd0);

    // Reset after the second captured word
    d0 = done_cnt;
    push(CMD_ADDR, 32'h0000_0004);
    push(STAT_ADDR, 32'h4000_0004);
    push(15'(BUF_BASE), 32'hE0);
    push(15'(BUF_BASE + 1), 32'hE1);
    mem[CMD_ADDR] = 32'h8000_0004;
    wait_ready();
    stream(2, 32'hE0, 16'hFFFF);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_ready", {31'b0, s_ready}, 32'd0);
    chk("mid_rst_cs", {31'b0, mem_chipselect}, 32'd0);
    chk("mid_rst_write", {31'b0, mem_write}, 32'd0);
    chk("mid_rst_addr", {17'b0, mem_address}, 32'd0);
    chk("mid_rst_wdata", mem_writedata, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_done", {31'b0, done_pulse}, 32'd0);
    chk("mid_rst_clken", {31'b0, mem_clken}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    busy_seen = 0;
    repeat (50) @(negedge clk);
    chk("post_rst_busy", {31'b0, busy_seen}, 32'd0);
    chk("post_rst_status", mem[STAT_ADDR], 32'h4000_0004);
    chk("post_rst_no_done", done_cnt - d0, 32'd0);
    chk("queue_empty_t6", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
